// File: rtl/pixel_window_stream_if.sv
// Pixel stream bundle for pixel_window_stream: raster input with valid/sof, window output and frame status.
// PIXEL_WINDOW_COORD_EN adds the window-centre coordinate outputs.
interface pixel_window_stream_if #(
   parameter int PIXEL_W = 8,
   parameter int WIN     = 5,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480
);
   logic                       in_valid;
   logic                       in_sof;
   logic [PIXEL_W-1:0]         incoming_pixel;
   logic                       out_valid;
   logic [WIN*WIN*PIXEL_W-1:0] out_pixel;
   logic                       frame_done;
   logic                       sof_err;
`ifdef PIXEL_WINDOW_COORD_EN
   logic [$clog2(IMG_W)-1:0]   out_col;
   logic [$clog2(IMG_H)-1:0]   out_row;

   modport master (
      output in_valid, in_sof, incoming_pixel,
      input  out_valid, out_pixel, frame_done, sof_err, out_col, out_row
   );

   modport slave (
      input  in_valid, in_sof, incoming_pixel,
      output out_valid, out_pixel, frame_done, sof_err, out_col, out_row
   );
`else
   modport master (
      output in_valid, in_sof, incoming_pixel,
      input  out_valid, out_pixel, frame_done, sof_err
   );

   modport slave (
      input  in_valid, in_sof, incoming_pixel,
      output out_valid, out_pixel, frame_done, sof_err
   );
`endif
endinterface

// File: rtl/pixel_window_stream.sv
// Streaming WIN x WIN neighbourhood generator for raster pixel streams with frame tracking.
// Optional macro PIXEL_WINDOW_COORD_EN adds registered window-centre coordinates (out_row/out_col).
module pixel_window_stream #(
   parameter int PIXEL_W = 8,
   parameter int WIN     = 5,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480
) (
   input logic                  clk,
   input logic                  rst,
   pixel_window_stream_if.slave bus
);

   localparam int COL_W    = $clog2(IMG_W);
   localparam int ROW_W    = $clog2(IMG_H);
   localparam int HALF     = (WIN - 1) / 2;
   localparam int WIN_BITS = WIN * WIN * PIXEL_W;

   typedef enum logic {
      WAIT_SOF,
      ACTIVE
   } state_e;

   typedef logic [PIXEL_W-1:0] pixel_t;

   state_e              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    cur_col;
   logic [ROW_W-1:0]    cur_row;
   logic                accept;
   logic                last_px;
   logic                out_valid_q, out_valid_d;
   logic                frame_done_q, frame_done_d;
   logic                sof_err_q, sof_err_d;
   logic [WIN_BITS-1:0] out_pixel_q;
   logic [WIN_BITS-1:0] win_flat;

   pixel_t lb_mem [WIN-1][IMG_W];
   pixel_t col_pix [WIN];
   pixel_t win_q [WIN][WIN];
   pixel_t win_d [WIN][WIN];

   // ---------------------------------------------------------------
   // Control: position of the pixel being accepted and next state
   // ---------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      cur_col      = col_q;
      cur_row      = row_q;
      accept       = 1'b0;
      last_px      = 1'b0;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      sof_err_d    = 1'b0;

      // An in_sof pixel is always (0,0) of a new frame, whatever the counters say.
      if (bus.in_sof) begin
         cur_col = '0;
         cur_row = '0;
      end

      case (state_q)
         WAIT_SOF: begin
            if (bus.in_valid && bus.in_sof) begin
               accept  = 1'b1;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.in_valid) begin
               accept = 1'b1;
               if (bus.in_sof && ((row_q != '0) || (col_q != '0))) begin
                  sof_err_d = 1'b1;
               end
            end
         end
         default: state_d = WAIT_SOF;
      endcase

      if (accept) begin
         out_valid_d = (cur_row >= ROW_W'(WIN - 1)) && (cur_col >= COL_W'(WIN - 1));
         last_px     = (cur_row == ROW_W'(IMG_H - 1)) && (cur_col == COL_W'(IMG_W - 1));
         if (last_px) begin
            state_d      = WAIT_SOF;
            col_d        = '0;
            row_d        = '0;
            frame_done_d = 1'b1;
         end else if (cur_col == COL_W'(IMG_W - 1)) begin
            col_d = '0;
            row_d = cur_row + ROW_W'(1);
         end else begin
            col_d = cur_col + COL_W'(1);
            row_d = cur_row;
         end
      end
   end

   // ---------------------------------------------------------------
   // Datapath: vertical column from line buffers, shifted window
   // ---------------------------------------------------------------
   always_comb begin
      col_pix[WIN-1] = bus.incoming_pixel;
      for (int k = 0; k < WIN - 1; k++) begin
         col_pix[WIN-2-k] = lb_mem[k][cur_col];
      end
   end

   always_comb begin
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN - 1; c++) begin
            win_d[r][c] = win_q[r][c+1];
         end
         win_d[r][WIN-1] = col_pix[r];
      end
   end

   always_comb begin
      win_flat = '0;
      for (int r = 0; r < WIN; r++) begin
         for (int c = 0; c < WIN; c++) begin
            win_flat[(r*WIN+c)*PIXEL_W +: PIXEL_W] = win_d[r][c];
         end
      end
   end

   // NOTE: the line buffers have no reset; out_valid gating keeps their power-up contents invisible.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int k = 0; k < WIN - 1; k++) begin
            lb_mem[k][cur_col] <= col_pix[WIN-1-k];
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= WAIT_SOF;
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         out_pixel_q  <= '0;
         for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
         sof_err_q    <= sof_err_d;
         if (accept) begin
            win_q <= win_d;
         end
         if (out_valid_d) begin
            out_pixel_q <= win_flat;
         end
      end
   end

`ifdef PIXEL_WINDOW_COORD_EN
   logic [COL_W-1:0] out_col_q;
   logic [ROW_W-1:0] out_row_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_col_q <= '0;
         out_row_q <= '0;
      end else if (out_valid_d) begin
         out_col_q <= cur_col - COL_W'(HALF);
         out_row_q <= cur_row - ROW_W'(HALF);
      end
   end

   assign bus.out_col = out_col_q;
   assign bus.out_row = out_row_q;
`endif

   assign bus.out_valid  = out_valid_q;
   assign bus.out_pixel  = out_pixel_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sof_err    = sof_err_q;

endmodule

// File: doc/pixel_window_stream.md
Name: pixel_window_stream

Overview:
- Parametrised streaming WIN x WIN neighbourhood generator for raster-order pixel streams. Successor to the fixed 5x5, 8-bit pixel_window.
- Adds:
  - configurable pixel width, kernel size and image geometry;
  - input valid qualification;
  - frame start/end tracking;
  - an output valid that asserts only for fully populated, in-image windows.
- Sits between the camera/pixel source and the convolution/filter stages.

Parameters:
- PIXEL_W, 8: bits per pixel.
- WIN, 5: window edge length. Must be odd and >= 3.
- IMG_W, 640: pixels per line. Must be >= WIN.
- IMG_H, 480: lines per frame. Must be >= WIN.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  incoming_pixel is valid this cycle.
- in_sof  in  1  start of frame. Qualified by in_valid; marks pixel (row 0, col 0).
- incoming_pixel  in  PIXEL_W  pixel data, raster order.
- out_valid  out  1  out_pixel holds a complete window.
- out_pixel  out  WIN*WIN*PIXEL_W  packed window. Tap (r,c) is at bits [(r*WIN+c)*PIXEL_W +: PIXEL_W]. r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- sof_err  out  1  one-cycle pulse when in_sof arrives mid-frame.

Behaviour:
- Reset values: out_valid=0, out_pixel=0, frame_done=0, sof_err=0, state=WAIT_SOF, row/col counters=0, window register=0. Line-buffer RAM is not cleared; out_valid gating guarantees stale data is never presented.
- States:
  - WAIT_SOF:
    - in_valid without in_sof: pixel dropped, no state change.
    - in_valid & in_sof: accept pixel as (0,0), go to ACTIVE.
  - ACTIVE:
    - Each in_valid pixel advances col.
    - col wraps IMG_W-1 -> 0 and increments row.
    - Acceptance of pixel (IMG_H-1, IMG_W-1): frame_done pulses next cycle, state returns to WAIT_SOF.
    - in_valid & in_sof while ACTIVE at any position other than (0,0): sof_err pulses next cycle, counters restart with this pixel as (0,0), state stays ACTIVE.
- Storage:
  - WIN-1 line buffers, each IMG_W deep, addressed by col.
  - Read-before-write on the same accepted cycle.
  - The buffers form a vertical column of WIN pixels: the WIN-1 previous lines plus the current pixel.
  - The column shifts into a WIN x WIN register; the new column enters at c=WIN-1.
- Stalls: in_valid low means no counter, buffer or window change, and out_valid=0 that cycle.
- Output:
  - Latency is 1 cycle: the window containing the pixel accepted at edge N is registered at edge N+1.
  - out_valid=1 iff that accepted pixel had row >= WIN-1 and col >= WIN-1. Windows that would straddle a line wrap are therefore never flagged valid.
  - The window centre is (row-(WIN-1)/2, col-(WIN-1)/2).
  - There are (IMG_W-WIN+1)*(IMG_H-WIN+1) valid windows per frame.
  - out_pixel holds its value when out_valid=0.
- Simultaneous last pixel and in_sof on the same pixel: treated as a restart (sof_err); frame_done is not pulsed.
- Asynchronous reset mid-frame:
  - all outputs drop immediately;
  - state returns to WAIT_SOF;
  - the next frame needs in_sof.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H).

Optional Feature:
- Macro: PIXEL_WINDOW_COORD_EN.
- Defined:
  - adds output ports out_col [$clog2(IMG_W)-1:0] and out_row [$clog2(IMG_H)-1:0];
  - they carry the centre coordinates of the current window;
  - they update with out_valid and reset to 0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Baseline frame: WIN=3, IMG_W=8, IMG_H=6, PIXEL_W=8; continuous in_valid, pixel = row*8+col, in_sof on the first pixel.
  - First out_valid one cycle after pixel 18 (row 2, col 2) is accepted.
  - Taps (0,0)=0, (1,1)=9, (2,2)=18.
  - Exactly 24 valid windows.
  - frame_done one cycle after pixel 47.
- Input gaps: same frame with in_valid deasserted every third cycle.
  - Identical sequence of 24 windows.
  - out_valid never asserts on idle cycles.
- No in_sof: 10 valid pixels in WAIT_SOF without in_sof.
  - All dropped; no out_valid.
  - The subsequent in_sof frame matches the baseline.
- Mid-frame restart: in_sof at pixel 20.
  - sof_err pulses once.
  - The next valid window has top-left tap = value of the restart pixel's frame (0,0) and occurs at the new (2,2).
  - No window mixes old-frame data.
- Reset mid-frame: rst pulsed at pixel 30.
  - out_valid and frame_done are 0 immediately.
  - The following clean frame reproduces the baseline.
- Coordinates and default size: with PIXEL_WINDOW_COORD_EN defined, out_row/out_col of the first window = (1,1) and of the last = (4,6). Also rerun with WIN=5, PIXEL_W=8: first window centre tap (2,2)=18.
